// File: rtl/tx_feeder.sv
// -----------------------------------------------------------------------------
// tx_feeder
//   Circular FIFO that buffers producer words and feeds them, one frame at a
//   time, to a UART transmitter through a request/acknowledge handshake.
//
// Ports
//   CLK        in   clock, rising edge
//   RST        in   asynchronous reset, active low
//   WR_EN      in   producer write strobe (one word per cycle)
//   WR_DATA    in   word to enqueue
//   FULL       out  FIFO holds DEPTH words
//   EMPTY      out  FIFO holds zero words
//   COUNT      out  FIFO occupancy (the word held in P_DATA is not counted)
//   OVERFLOW   out  sticky: a write was attempted while FULL
//   P_DATA     out  registered word presented to the transmitter
//   DATA_VALID out  registered request to the transmitter to accept P_DATA
//   DATA_OK    in   transmitter acknowledge, one cycle
//   Busy       in   transmitter frame-in-progress
//   DBG_STATE  out  control FSM state (IDLE=0, REQ=1, WAIT_BUSY=2, WAIT_DONE=3)
//
// Handshake: the FSM pops the head word into P_DATA when it leaves IDLE and
// raises DATA_VALID for as long as it sits in REQ. DATA_OK is only honoured
// in REQ. After the acknowledge the FSM waits for Busy to rise and then fall
// before it may pop the next word, so frames can never overlap.
// -----------------------------------------------------------------------------
module tx_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = AW + 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WR_EN,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic [CW-1:0]         COUNT,
  output logic                  OVERFLOW,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  input  logic                  DATA_OK,
  input  logic                  Busy,
  output logic [1:0]            DBG_STATE
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  do_write;
  logic                  do_pop;

  // A write to a full FIFO is rejected even when a pop frees a slot in the
  // same cycle; FULL is the registered flag, not a look-ahead.
  assign do_write = WR_EN && !full_q;
  assign do_pop   = (state_q == IDLE) && !empty_q;

  // Storage is not reset; only pointers/count define what is valid.
  always_ff @(posedge CLK) begin
    if (do_write) begin
      mem_q[wr_ptr_q] <= WR_DATA;
    end
  end

  // Datapath next-state: pointers wrap naturally at DEPTH (power of two).
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    p_data_d   = p_data_q;
    if (do_write) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      p_data_d = mem_q[rd_ptr_q];
    end
    if (WR_EN && full_q) begin
      overflow_d = 1'b1;
    end
    case ({do_write, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  // Control FSM next-state; DATA_VALID is registered from the next state so
  // it is a clean flop output that is high exactly while the FSM is in REQ.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (!empty_q) state_d = REQ;
      REQ:       if (DATA_OK)  state_d = WAIT_BUSY;
      WAIT_BUSY: if (Busy)     state_d = WAIT_DONE;
      WAIT_DONE: if (!Busy)    state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
    data_valid_d = (state_d == REQ);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      overflow_q   <= 1'b0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      overflow_q   <= overflow_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign FULL       = full_q;
  assign EMPTY      = empty_q;
  assign COUNT      = count_q;
  assign OVERFLOW   = overflow_q;
  assign P_DATA     = p_data_q;
  assign DATA_VALID = data_valid_q;
  assign DBG_STATE  = state_q;

endmodule

// File: tb/tb_tx_feeder.sv
// -----------------------------------------------------------------------------
// tb_tx_feeder
//   Self-checking bench for tx_feeder (DATA_WIDTH=8, DEPTH=8): a cycle table
//   with manually driven handshake inputs, hand-written corner sequences, and
//   a randomized run against a transmitter model plus an expected-word queue.
// -----------------------------------------------------------------------------
module tb_tx_feeder;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic          CLK;
  logic          RST;
  logic          WR_EN;
  logic [DW-1:0] WR_DATA;
  logic          FULL;
  logic          EMPTY;
  logic [CW-1:0] COUNT;
  logic          OVERFLOW;
  logic [DW-1:0] P_DATA;
  logic          DATA_VALID;
  logic          DATA_OK;
  logic          Busy;
  logic [1:0]    DBG_STATE;

  tx_feeder #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .WR_EN     (WR_EN),
    .WR_DATA   (WR_DATA),
    .FULL      (FULL),
    .EMPTY     (EMPTY),
    .COUNT     (COUNT),
    .OVERFLOW  (OVERFLOW),
    .P_DATA    (P_DATA),
    .DATA_VALID(DATA_VALID),
    .DATA_OK   (DATA_OK),
    .Busy      (Busy),
    .DBG_STATE (DBG_STATE)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---------------- scoreboard state ----------------
  int            n_compared   = 0;
  int            n_mismatched = 0;
  logic [DW-1:0] exp_q[$];
  int            frames_acked   = 0;
  int            valid_hi_cycles = 0;
  int            protocol_errs  = 0;

  // transmitter model controls
  bit            tx_auto       = 1'b0;
  int            tx_busy_fixed = 10;   // < 0 selects a random 1..4 cycle frame
  int            tx_busy_left  = 0;
  bit            valid_seen    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic score_frame(input logic [DW-1:0] word);
    logic [DW-1:0] e;
    n_compared++;
    if (exp_q.size() == 0) begin
      n_mismatched++;
      $display("FAIL frame_unexpected: got 0x%0h expected none", word);
    end else begin
      e = exp_q.pop_front();
      if (word !== e) begin
        n_mismatched++;
        $display("FAIL frame_data: got 0x%0h expected 0x%0h", word, e);
      end
    end
  endtask

  // Transmitter model: acknowledges one cycle after it first sees DATA_VALID,
  // then holds Busy for a frame time. Outputs sampled on the falling edge.
  initial begin
    forever begin
      @(negedge CLK);
      if (tx_auto) begin
        DATA_OK = 1'b0;
        if (tx_busy_left > 0) begin
          Busy = 1'b1;
          tx_busy_left--;
        end else begin
          Busy = 1'b0;
          if (DATA_VALID) begin
            if (valid_seen) begin
              DATA_OK    = 1'b1;
              valid_seen = 1'b0;
              frames_acked++;
              score_frame(P_DATA);
              tx_busy_left = (tx_busy_fixed < 0) ? int'($urandom_range(4, 1)) : tx_busy_fixed;
            end else begin
              valid_seen = 1'b1;
            end
          end else begin
            valid_seen = 1'b0;
          end
        end
        if (Busy && DATA_VALID) protocol_errs++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      if (DATA_VALID) valid_hi_cycles++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge CLK);
    RST          = 1'b0;
    WR_EN        = 1'b0;
    WR_DATA      = '0;
    tx_auto      = 1'b0;
    DATA_OK      = 1'b0;
    Busy         = 1'b0;
    tx_busy_left = 0;
    valid_seen   = 1'b0;
    exp_q.delete();
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic write_word(input logic [DW-1:0] d, input bit accepted);
    @(negedge CLK);
    WR_EN   = 1'b1;
    WR_DATA = d;
    if (accepted) exp_q.push_back(d);
  endtask

  task automatic write_stop();
    @(negedge CLK);
    WR_EN = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, input string name);
    int k;
    k = 0;
    while (DBG_STATE !== s && k < budget) begin
      @(negedge CLK);
      k++;
    end
    if (DBG_STATE !== s) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL %s: timeout, state %0d expected %0d", name, DBG_STATE, s);
    end
  endtask

  task automatic wait_frames(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (!(frames_acked >= target && DBG_STATE == 2'd0) && k < budget) begin
      @(negedge CLK);
      k++;
    end
    if (!(frames_acked >= target && DBG_STATE == 2'd0)) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL %s: timeout, frames %0d expected %0d", name, frames_acked, target);
    end
  endtask

  // ---------------- cycle table ----------------
  typedef struct {
    logic          wr;
    logic [DW-1:0] d;
    logic          dok;
    logic          busy;
    logic [CW-1:0] count;
    logic          empty;
    logic          valid;
    logic [DW-1:0] pdata;
    logic [1:0]    state;
  } vec_t;

  vec_t vecs[11];

  // ---------------- test sequence ----------------
  initial begin
    int base;
    int wr_total;

    RST = 1'b0; WR_EN = 1'b0; WR_DATA = '0; DATA_OK = 1'b0; Busy = 1'b0;

    // Expected state after each rising edge, derived from the handshake rules.
    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 8'h00, 2'd0}; // write
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 8'hA5, 2'd1}; // pop
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 8'hA5, 2'd1}; // hold REQ
    vecs[3]  = '{1'b1, 8'h11, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 8'hA5, 2'd2}; // ack + write
    vecs[4]  = '{1'b1, 8'h22, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 8'hA5, 2'd2}; // stray ack ignored
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 8'hA5, 2'd3}; // busy rise
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 4'd2, 1'b0, 1'b0, 8'hA5, 2'd3}; // ack in WAIT_DONE
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 8'hA5, 2'd0}; // busy fall
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd1, 1'b0, 1'b1, 8'h11, 2'd1}; // pop, busy ignored
    vecs[9]  = '{1'b1, 8'h33, 1'b0, 1'b1, 4'd2, 1'b0, 1'b1, 8'h11, 2'd1}; // busy ignored in REQ
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 8'h11, 2'd2}; // ack

    // Reset values while RST is held low
    #12;
    check("rst_count",    32'(COUNT),      32'd0);
    check("rst_empty",    32'(EMPTY),      32'd1);
    check("rst_full",     32'(FULL),       32'd0);
    check("rst_overflow", 32'(OVERFLOW),   32'd0);
    check("rst_pdata",    32'(P_DATA),     32'd0);
    check("rst_valid",    32'(DATA_VALID), 32'd0);
    check("rst_state",    32'(DBG_STATE),  32'd0);
    do_reset();

    // ---- table-driven cycle vectors ----
    for (int i = 0; i < 11; i++) begin
      @(negedge CLK);
      WR_EN = vecs[i].wr; WR_DATA = vecs[i].d; DATA_OK = vecs[i].dok; Busy = vecs[i].busy;
      @(posedge CLK);
      #1;
      check($sformatf("vec%0d_count", i), 32'(COUNT),      32'(vecs[i].count));
      check($sformatf("vec%0d_empty", i), 32'(EMPTY),      32'(vecs[i].empty));
      check($sformatf("vec%0d_valid", i), 32'(DATA_VALID), 32'(vecs[i].valid));
      check($sformatf("vec%0d_pdata", i), 32'(P_DATA),     32'(vecs[i].pdata));
      check($sformatf("vec%0d_state", i), 32'(DBG_STATE),  32'(vecs[i].state));
    end

    // ---- single word, latency and DATA_VALID width ----
    do_reset();
    tx_auto = 1'b1; tx_busy_fixed = 10;
    base = frames_acked;
    @(negedge CLK);
    valid_hi_cycles = 0;
    WR_EN = 1'b1; WR_DATA = 8'hA5; exp_q.push_back(8'hA5);
    @(posedge CLK); #1;
    check("lat_count_after_write", 32'(COUNT),      32'd1);
    check("lat_valid_after_write", 32'(DATA_VALID), 32'd0);
    @(negedge CLK); WR_EN = 1'b0;
    @(posedge CLK); #1;
    check("lat_valid_after_pop", 32'(DATA_VALID), 32'd1);
    check("lat_pdata_after_pop", 32'(P_DATA),     32'hA5);
    check("lat_count_after_pop", 32'(COUNT),      32'd0);
    wait_frames(base + 1, 100, "single_drain");
    check("single_frames",      32'(frames_acked - base), 32'd1);
    check("single_valid_width", 32'(valid_hi_cycles),     32'd2);
    check("single_count",       32'(COUNT),               32'd0);

    // ---- fill, overflow, drain ----
    do_reset();
    for (int i = 1; i <= 11; i++) begin
      write_word(8'(i), i <= 9);
      if (i == 9) begin
        check("fill_count7", 32'(COUNT), 32'd7);
        check("fill_full0",  32'(FULL),  32'd0);
      end
      if (i == 10) begin
        check("fill_count8",  32'(COUNT),    32'd8);
        check("fill_full1",   32'(FULL),     32'd1);
        check("fill_ovf0",    32'(OVERFLOW), 32'd0);
      end
      if (i == 11) begin
        check("ovf_set",      32'(OVERFLOW), 32'd1);
        check("ovf_count8",   32'(COUNT),    32'd8);
      end
    end
    write_stop();
    check("ovf_pdata_first", 32'(P_DATA), 32'h01);
    check("ovf_count_hold",  32'(COUNT),  32'd8);
    base = frames_acked;
    valid_seen = 1'b0; tx_busy_fixed = 3; tx_auto = 1'b1;
    wait_frames(base + 9, 400, "fill_drain");
    check("drain_frames",   32'(frames_acked - base), 32'd9);
    check("drain_empty",    32'(EMPTY),               32'd1);
    check("drain_count",    32'(COUNT),               32'd0);
    check("drain_ovf_held", 32'(OVERFLOW),            32'd1);
    check("drain_expq",     32'(exp_q.size()),        32'd0);
    do_reset();
    check("ovf_cleared", 32'(OVERFLOW), 32'd0);

    // ---- simultaneous write and pop at COUNT=3 with pointer wrap ----
    for (int i = 0; i < 4; i++) write_word(8'h80 + 8'(i), 1'b1);
    write_stop();
    check("sim_count3_start", 32'(COUNT), 32'd3);
    base = frames_acked;
    valid_seen = 1'b0; tx_busy_fixed = 2; tx_auto = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wait_state(2'd0, 50, "sim_wait_idle");
      WR_EN = 1'b1; WR_DATA = 8'h90 + 8'(i); exp_q.push_back(WR_DATA);
      @(posedge CLK); #1;
      check($sformatf("sim_count3_%0d", i), 32'(COUNT), 32'd3);
      @(negedge CLK); WR_EN = 1'b0;
    end
    wait_frames(base + 24, 1000, "sim_drain");
    check("sim_empty", 32'(EMPTY),         32'd1);
    check("sim_expq",  32'(exp_q.size()), 32'd0);

    // ---- reset asserted in WAIT_DONE with COUNT=4 ----
    do_reset();
    tx_auto = 1'b1; tx_busy_fixed = 10;
    for (int i = 0; i < 5; i++) write_word(8'h40 + 8'(i), 1'b1);
    write_stop();
    wait_state(2'd3, 30, "rst_mid_wait_done");
    check("rst_mid_pre_count", 32'(COUNT), 32'd4);
    #2;
    RST = 1'b0;
    tx_auto = 1'b0; DATA_OK = 1'b0; Busy = 1'b0; tx_busy_left = 0; valid_seen = 1'b0;
    exp_q.delete();
    #1;
    check("rst_mid_state", 32'(DBG_STATE),  32'd0);
    check("rst_mid_valid", 32'(DATA_VALID), 32'd0);
    check("rst_mid_count", 32'(COUNT),      32'd0);
    check("rst_mid_empty", 32'(EMPTY),      32'd1);
    check("rst_mid_pdata", 32'(P_DATA),     32'd0);
    @(negedge CLK); @(negedge CLK);
    RST = 1'b1;
    tx_auto = 1'b1;
    valid_hi_cycles = 0;
    repeat (20) @(negedge CLK);
    check("rst_mid_no_valid", 32'(valid_hi_cycles), 32'd0);
    base = frames_acked;
    write_word(8'h55, 1'b1);
    write_stop();
    wait_frames(base + 1, 100, "rst_mid_new_word");

    // ---- Busy never rises after DATA_OK ----
    do_reset();
    tx_auto = 1'b1; tx_busy_fixed = 0;
    base = frames_acked;
    valid_hi_cycles = 0;
    write_word(8'h66, 1'b1);
    write_stop();
    repeat (5) @(negedge CLK);
    write_word(8'h77, 1'b1);
    write_stop();
    repeat (15) @(negedge CLK);
    check("nobusy_frames", 32'(frames_acked - base), 32'd1);
    check("nobusy_state",  32'(DBG_STATE),           32'd2);
    check("nobusy_valid",  32'(valid_hi_cycles),     32'd2);
    check("nobusy_pdata",  32'(P_DATA),              32'h66);
    check("nobusy_count",  32'(COUNT),               32'd1);

    // ---- randomized traffic against the model ----
    do_reset();
    tx_auto = 1'b1; tx_busy_fixed = -1;
    protocol_errs = 0;
    base = frames_acked;
    wr_total = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge CLK);
      // FIFO occupancy never exceeds writes minus acknowledged frames, so this
      // keeps every random write within capacity.
      if ($urandom_range(2, 0) == 0 && (wr_total - (frames_acked - base)) < DEPTH) begin
        WR_EN = 1'b1; WR_DATA = 8'($urandom); exp_q.push_back(WR_DATA); wr_total++;
      end else begin
        WR_EN = 1'b0;
      end
    end
    write_stop();
    wait_frames(base + wr_total, 2000, "rand_drain");
    check("rand_frames",   32'(frames_acked - base), 32'(wr_total));
    check("rand_expq",     32'(exp_q.size()),        32'd0);
    check("rand_empty",    32'(EMPTY),               32'd1);
    check("rand_count",    32'(COUNT),               32'd0);
    check("rand_ovf",      32'(OVERFLOW),            32'd0);
    check("rand_protocol", 32'(protocol_errs),       32'd0);

    // ---- report ----
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
